// File: rtl/led_scan_controller_if.sv
// Frame handshake between the game-of-life engine (master) and the LED scan controller (slave).
interface led_scan_controller_if #(
    parameter int N = 8
);
    logic [N*N-1:0] cells_in;
    logic           cells_valid;
    logic           cells_ready;

    modport master (output cells_in, output cells_valid, input  cells_ready);
    modport slave  (input  cells_in, input  cells_valid, output cells_ready);
endinterface

// File: rtl/led_scan_controller.sv
// Column-scanning LED matrix controller: lights each column for DWELL cycles, blanks for BLANK cycles,
// and double-buffers frames so the displayed frame only changes at a frame boundary.
module led_scan_controller #(
    parameter int N     = 8,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    led_scan_controller_if.slave frame_if,
    output logic [$clog2(N):0]   x,
    output logic                 x_ena,
    output logic [N*N-1:0]       cells_out,
    output logic                 frame_done
);
    localparam int XW   = $clog2(N) + 1;
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [XW-1:0] X_LAST      = XW'(N - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST  = (BLANK > 0) ? CW'(BLANK - 1) : '0;

    if (N < 1 || N > 8) begin : g_bad_n
        $error("led_scan_controller: N must be in 1..8");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("led_scan_controller: DWELL must be >= 1");
    end
    if (BLANK < 0) begin : g_bad_blank
        $error("led_scan_controller: BLANK must be >= 0");
    end

    typedef enum logic [1:0] {IDLE, SHOW, BLANK_S} state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d, x_next;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           x_ena_q, x_ena_d;
    logic           done_q, done_d;
    logic           boundary;
    logic [N*N-1:0] pending_q, display_q;
    logic           pfull_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        x_next   = (x_q == X_LAST) ? '0 : x_q + 1'b1;
        if (!ena) begin
            state_d = IDLE;
            x_d     = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    x_d     = '0;
                    cnt_d   = '0;
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (BLANK > 0) begin
                            state_d = BLANK_S;
                        end else begin
                            x_d      = x_next;
                            boundary = (x_q == X_LAST);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BLANK_S: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d  = SHOW;
                        cnt_d    = '0;
                        x_d      = x_next;
                        boundary = (x_q == X_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    x_d     = '0;
                    cnt_d   = '0;
                end
            endcase
        end
        x_ena_d = (state_d == SHOW);
        // frame_done marks the last cycle of a frame, so it is raised when entering that cycle
        if (BLANK > 0) begin
            done_d = (x_d == X_LAST) && (state_d == BLANK_S) && (cnt_d == BLANK_LAST);
        end else begin
            done_d = (x_d == X_LAST) && (state_d == SHOW) && (cnt_d == DWELL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            x_ena_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            x_ena_q <= x_ena_d;
            done_q  <= done_d;
        end
    end

    // Accept only into an empty pending buffer; commit only from a full one, so the two never collide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            display_q <= '0;
            pfull_q   <= 1'b0;
        end else if (boundary && pfull_q) begin
            display_q <= pending_q;
            pfull_q   <= 1'b0;
        end else if (frame_if.cells_valid && !pfull_q) begin
            pending_q <= frame_if.cells_in;
            pfull_q   <= 1'b1;
        end
    end

    assign frame_if.cells_ready = ~pfull_q;
    assign x          = x_q;
    assign x_ena      = x_ena_q;
    assign cells_out  = display_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_led_scan_controller.sv
// Self-checking bench: arithmetic timing model (column = t / period) plus a pending/display frame model.
module tb_led_scan_controller;
    localparam int N  = 8;
    localparam int DW = 4;
    localparam int BL = 1;
    localparam int P  = DW + BL;
    localparam int FP = N * P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic ena1 = 1'b0;

    logic [3:0]  x0, x1;
    logic        x_ena0, x_ena1, fd0, fd1;
    logic [63:0] co0, co1;

    int pass_cnt = 0;
    int total_cnt = 0;

    // reference model state
    bit          m_scan = 1'b0;
    int          m_t = 0;
    logic [63:0] m_disp = '0;
    logic [63:0] m_pend = '0;
    bit          m_pfull = 1'b0;

    led_scan_controller_if #(.N(N)) if0 ();
    led_scan_controller_if #(.N(N)) if1 ();

    led_scan_controller #(.N(N), .DWELL(DW), .BLANK(BL)) dut (
        .clk(clk), .rst(rst), .ena(ena), .frame_if(if0),
        .x(x0), .x_ena(x_ena0), .cells_out(co0), .frame_done(fd0)
    );

    led_scan_controller #(.N(N), .DWELL(4), .BLANK(0)) dut_b0 (
        .clk(clk), .rst(rst), .ena(ena1), .frame_if(if1),
        .x(x1), .x_ena(x_ena1), .cells_out(co1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_scan = 1'b0; m_t = 0; m_disp = '0; m_pend = '0; m_pfull = 1'b0;
    endfunction

    function automatic void model_step();
        bit bnd;
        bnd = m_scan && ena && ((m_t % FP) == FP - 1);
        if (bnd && m_pfull) begin
            m_disp = m_pend; m_pfull = 1'b0;
        end else if (if0.cells_valid && !m_pfull) begin
            m_pend = if0.cells_in; m_pfull = 1'b1;
        end
        if (!ena) begin m_scan = 1'b0; m_t = 0; end
        else if (!m_scan) begin m_scan = 1'b1; m_t = 0; end
        else m_t++;
    endfunction

    function automatic int m_x();
        return m_scan ? (m_t / P) % N : 0;
    endfunction

    function automatic logic [6:0] exp_ctl();
        logic [3:0] ex;
        logic xe, fd;
        ex = 4'(m_x());
        xe = m_scan && ((m_t % P) < DW);
        fd = m_scan && ((m_t % FP) == FP - 1);
        return {ex, xe, fd, ~m_pfull};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        if0.cells_valid = 1'b0; if0.cells_in = '0;
        if1.cells_valid = 1'b0; if1.cells_in = '0;
        #1 rst = 1'b0;
        model_reset();
        #2;
        total_cnt++;
        if ({x0, x_ena0, fd0, if0.cells_ready} !== 7'b0000001)
            $display("FAIL reset_ctl: got %b expected %b", {x0, x_ena0, fd0, if0.cells_ready}, 7'b0000001);
        else pass_cnt++;
        total_cnt++;
        if (co0 !== 64'h0) $display("FAIL reset_cells: got %h expected %h", co0, 64'h0);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if ({x0, x_ena0, fd0, if0.cells_ready} !== exp_ctl())
                $display("FAIL idle_ctl: got %b expected %b", {x0, x_ena0, fd0, if0.cells_ready}, exp_ctl());
            else pass_cnt++;
        end
    endtask

    task automatic test_blank_zero();
        int t1;
        logic [5:0] e;
        ena1 = 1'b1;
        for (t1 = 0; t1 < 70; t1++) begin
            tick();
            e = {4'((t1 / 4) % 8), 1'b1, (t1 % 32) == 31};
            total_cnt++;
            if ({x1, x_ena1, fd1} !== e)
                $display("FAIL blank0_t%0d: got %b expected %b", t1, {x1, x_ena1, fd1}, e);
            else pass_cnt++;
        end
        ena1 = 1'b0;
    endtask

    task automatic test_scan_timing();
        ena = 1'b1;
        for (int c = 1; c <= 85; c++) begin
            tick();
            total_cnt++;
            if ({x0, x_ena0, fd0, if0.cells_ready} !== exp_ctl())
                $display("FAIL scan_c%0d: got %b expected %b", c, {x0, x_ena0, fd0, if0.cells_ready}, exp_ctl());
            else pass_cnt++;
            if (c == 40) begin
                total_cnt++;
                if (fd0 !== 1'b1) $display("FAIL scan_done40: got %b expected 1", fd0);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_frame_handshake();
        logic [63:0] pat;
        pat = 64'hFF00_FF00_FF00_FF00;
        if0.cells_in = pat; if0.cells_valid = 1'b1;
        tick();
        if0.cells_valid = 1'b0;
        total_cnt++;
        if (if0.cells_ready !== 1'b0) $display("FAIL hs_ready_low: got %b expected 0", if0.cells_ready);
        else pass_cnt++;
        for (int i = 0; i < FP + 2; i++) begin
            tick();
            total_cnt++;
            if (co0 !== m_disp || {x0, x_ena0, fd0, if0.cells_ready} !== exp_ctl())
                $display("FAIL hs_c%0d: got %h/%b expected %h/%b", i, co0, {x0, x_ena0, fd0, if0.cells_ready}, m_disp, exp_ctl());
            else pass_cnt++;
        end
        total_cnt++;
        if (co0 !== pat || if0.cells_ready !== 1'b1)
            $display("FAIL hs_committed: got %h/%b expected %h/1", co0, if0.cells_ready, pat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        int guard;
        a = 64'h0123_4567_89AB_CDEF;
        b = 64'hA5A5_5A5A_0F0F_F0F0;
        if0.cells_in = a; if0.cells_valid = 1'b1;
        tick();
        if0.cells_in = b;
        guard = 0;
        while (!(m_pfull && m_pend === b) && guard < 200) begin
            tick();
            guard++;
            total_cnt++;
            if (co0 !== m_disp || if0.cells_ready !== ~m_pfull)
                $display("FAIL b2b_wait: got %h/%b expected %h/%b", co0, if0.cells_ready, m_disp, ~m_pfull);
            else pass_cnt++;
        end
        if0.cells_valid = 1'b0;
        total_cnt++;
        if (guard >= 200) $display("FAIL b2b_timeout: got %0d cycles expected < 200", guard);
        else pass_cnt++;
        total_cnt++;
        if (co0 !== a) $display("FAIL b2b_a_shown: got %h expected %h", co0, a);
        else pass_cnt++;
        for (int i = 0; i < FP + 2; i++) begin
            tick();
            total_cnt++;
            if (co0 !== m_disp || {x0, x_ena0, fd0, if0.cells_ready} !== exp_ctl())
                $display("FAIL b2b_c%0d: got %h/%b expected %h/%b", i, co0, {x0, x_ena0, fd0, if0.cells_ready}, m_disp, exp_ctl());
            else pass_cnt++;
        end
        total_cnt++;
        if (co0 !== b) $display("FAIL b2b_b_shown: got %h expected %h", co0, b);
        else pass_cnt++;
    endtask

    task automatic test_ena_drop();
        int guard;
        logic [63:0] held;
        guard = 0;
        while (!(m_x() == 5 && (m_t % P) < DW - 1) && guard < 100) begin
            tick();
            guard++;
        end
        held = m_disp;
        ena = 1'b0;
        tick();
        total_cnt++;
        if ({x0, x_ena0, fd0} !== 6'b0 || co0 !== held)
            $display("FAIL ena_drop: got %b/%h expected 000000/%h", {x0, x_ena0, fd0}, co0, held);
        else pass_cnt++;
        ena = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total_cnt++;
            if (co0 !== held || {x0, x_ena0, fd0, if0.cells_ready} !== exp_ctl())
                $display("FAIL ena_restart_c%0d: got %h/%b expected %h/%b", i, co0, {x0, x_ena0, fd0, if0.cells_ready}, held, exp_ctl());
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midframe();
        int guard;
        guard = 0;
        while (m_x() != 3 && guard < 100) begin tick(); guard++; end
        if0.cells_in = 64'hDEAD_BEEF_CAFE_F00D; if0.cells_valid = 1'b1;
        tick();
        if0.cells_valid = 1'b0;
        while (m_x() != 7 && guard < 200) begin tick(); guard++; end
        total_cnt++;
        if (if0.cells_ready !== 1'b0 || x0 !== 4'd7)
            $display("FAIL rstmid_pre: got ready %b x %0d expected ready 0 x 7", if0.cells_ready, x0);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        model_reset();
        total_cnt++;
        if (co0 !== 64'h0 || {x0, x_ena0, fd0, if0.cells_ready} !== 7'b0000001)
            $display("FAIL rstmid_async: got %h/%b expected 0/%b", co0, {x0, x_ena0, fd0, if0.cells_ready}, 7'b0000001);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total_cnt++;
            if (co0 !== m_disp || {x0, x_ena0, fd0, if0.cells_ready} !== exp_ctl())
                $display("FAIL rstmid_c%0d: got %h/%b expected %h/%b", i, co0, {x0, x_ena0, fd0, if0.cells_ready}, m_disp, exp_ctl());
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            if0.cells_valid = ($urandom_range(3) == 0);
            if0.cells_in = {$urandom, $urandom};
            ena = ($urandom_range(59) != 0);
            tick();
            total_cnt++;
            if (co0 !== m_disp || {x0, x_ena0, fd0, if0.cells_ready} !== exp_ctl())
                $display("FAIL rand_c%0d: got %h/%b expected %h/%b", i, co0, {x0, x_ena0, fd0, if0.cells_ready}, m_disp, exp_ctl());
            else pass_cnt++;
        end
        if0.cells_valid = 1'b0;
        ena = 1'b1;
    endtask

    initial begin
        test_reset();
        test_blank_zero();
        test_scan_timing();
        test_frame_handshake();
        test_back_to_back();
        test_ena_drop();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/led_scan_controller.md
LED_SCAN_CONTROLLER -- requirements
Module: led_scan_controller

Interface
REQ-001 SHALL have parameter N, default 8, meaning Conway grid edge size; legal range 1..8, else $error at elaboration.
REQ-002 SHALL have parameter DWELL, default 1000, meaning clock cycles each column is lit; DWELL >= 1, else $error.
REQ-003 SHALL have parameter BLANK, default 16, meaning dark cycles between columns (anti-ghosting); BLANK >= 0.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ena  input  1  scan enable; low forces the display dark.
REQ-007 SHALL have port cells_in  input  N*N  new frame from the game-of-life engine, row i at bits [(i+1)*N-1:i*N].
REQ-008 SHALL have port cells_valid  input  1  cells_in holds a frame offered for display.
REQ-009 SHALL have port cells_ready  output  1  pending buffer empty; a frame is accepted on a clk edge with cells_valid && cells_ready.
REQ-010 SHALL have port x  output  $clog2(N)+1  current column index to the LED array driver.
REQ-011 SHALL have port x_ena  output  1  decoder enable to the LED array driver.
REQ-012 SHALL have port cells_out  output  N*N  frame being displayed, to the driver's cells input.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when a full scan of N columns completes.

Function
REQ-014 SHALL implement FSM states IDLE, SHOW, BLANK_S; all outputs registered.
REQ-015 SHALL hold two N*N buffers: pending (written by handshake) and display (drives cells_out), plus a pending_full flag.
REQ-016 SHALL drive cells_ready = ~pending_full; on accept, pending <= cells_in and pending_full <= 1 on the same edge.
REQ-017 SHALL ignore cells_in/cells_valid while cells_ready is low; pending is never overwritten.
REQ-018 IDLE: x_ena=0, x=0, dwell counter 0; on ena=1 go to SHOW next edge with x=0.
REQ-019 SHOW: x_ena=1 for exactly DWELL cycles, then BLANK_S (or, if BLANK=0, directly the next column's SHOW).
REQ-020 BLANK_S: x_ena=0 for exactly BLANK cycles, x held; on exit x advances by 1 and state returns to SHOW.
REQ-021 x SHALL wrap from N-1 to 0; that column-exit edge is the frame boundary.
REQ-022 At the frame boundary: frame_done=1 for one cycle; if pending_full, display <= pending and pending_full <= 0 on that same edge.
REQ-023 Frame commit SHALL occur only at a frame boundary, never mid-scan; cells_out is constant across a frame.
REQ-024 A frame accepted on the frame-boundary edge SHALL NOT occur (ready is low whenever commit is possible); if pending was empty, the accepted frame waits for the next boundary.
REQ-025 ena dropping in SHOW or BLANK_S SHALL take effect next edge: IDLE, x_ena=0, x=0, no frame_done, pending and display retained.
REQ-026 Column-lit-to-lit period SHALL be DWELL+BLANK cycles; frame period N*(DWELL+BLANK) cycles.
REQ-027 Counters SHALL be sized $clog2(max(DWELL,BLANK)+1) bits; no overflow at parameter extremes.

Reset
REQ-028 On rst=0 (asynchronous): state=IDLE, x=0, x_ena=0, frame_done=0, cells_out=0, pending=0, pending_full=0 (cells_ready=1).
REQ-029 Reset asserted mid-frame SHALL discard the pending frame and blank the display immediately; scan restarts from x=0 after release with ena=1.
REQ-030 Release SHALL be effective on the first rising edge with rst=1; no output glitches during reset.

Verification (N=8, DWELL=4, BLANK=1)
REQ-031 Reset release, ena=1 -> x_ena high for cycles 1-4 with x=0, low cycle 5, x=1 high cycles 6-9; frame_done at cycle 40 only.
REQ-032 cells_valid with 64'hFF00_... during scan -> cells_ready falls next cycle; cells_out unchanged until frame boundary, then equals 64'hFF00_... and cells_ready returns to 1.
REQ-033 Two back-to-back frames A,B offered -> A accepted, B stalled (ready low) until boundary; A displayed frame 2, B displayed frame 3.
REQ-034 ena dropped at x=5 mid-SHOW -> next cycle x_ena=0, x=0, no frame_done; ena re-raised -> scan restarts at x=0, cells_out unchanged.
REQ-035 rst asserted at x=7 with pending_full=1 -> immediately cells_out=0, cells_ready=1, x=0, x_ena=0.
REQ-036 BLANK=0 build -> x_ena continuously high, x increments every 4 cycles, frame_done every 32 cycles.
